// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory side of the CPU: the RAM handshake status,
// the machine word, and the arbiter FSM state encoding.
// No ports; imported by the arbiter interface, the arbiter and its bench.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // RAM status as reported back to the arbiter each cycle.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the cache-side requests and the RAM-side strobes of the memory
// arbiter.
//   slave  : the arbiter's view (requests and RAM status in; waits, loads
//            and RAM strobes out).
//   master : the environment's view (caches plus RAM model).
//
// Handshake: a cache raises xREN/xWEN with a stable address (and store data)
// and holds it until it samples its xwait low at a rising edge; that cycle is
// the single completion cycle and xload is valid only then. Dropping the
// request before that abandons the transfer. On the RAM side the arbiter
// holds ramREN/ramWEN/ramaddr/ramstore until ramstate reads ACCESS.
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   // icache side
   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;
   // dcache side
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;
   // RAM side
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Single-port RAM arbiter between the instruction and data caches.
// Data wins ties; after STARVE_LIMIT consecutive data completions while the
// icache is waiting, the icache is granted first.
//
// Ports:
//   CLK               in   clock, all state on rising edge
//   RST               in   synchronous active-high reset
//   bus               slave modport of mem_arbiter_if (cache + RAM signals)
//   dbg_state_o       out  current FSM state
//   dbg_starve_cnt_o  out  current starvation count
//
// Outputs on bus are decoded from the registered state plus live inputs, so
// a grant can complete in the first cycle the strobe is up.
// ----------------------------------------------------------------------------
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              CLK,
   input  logic              RST,
   mem_arbiter_if.slave      bus,
   output arb_state_t        dbg_state_o,
   output logic [CNT_W-1:0]  dbg_starve_cnt_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_cnt_d  = starve_cnt_q;
      bus.iwait     = 1'b1;
      bus.dwait     = 1'b1;
      bus.iload     = '0;
      bus.dload     = '0;
      bus.ramREN    = 1'b0;
      bus.ramWEN    = 1'b0;
      bus.ramaddr   = '0;
      bus.ramstore  = '0;

      case (state_q)
         IDLE: begin
            // Data wins unless the icache has been passed over too often.
            if ((bus.dREN || bus.dWEN) &&
                !(bus.iREN && (starve_cnt_q >= LIMIT))) begin
               state_d = DGNT;
            end else if (bus.iREN) begin
               state_d = IGNT;
            end
         end

         IGNT: begin
            if (!bus.iREN) begin
               // Request withdrawn: abandon silently.
               state_d = IDLE;
            end else begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.iaddr;
               // FREE, BUSY and ERROR all mean "keep holding".
               if (bus.ramstate == ACCESS) begin
                  bus.iwait    = 1'b0;
                  bus.iload    = bus.ramload;
                  starve_cnt_d = '0;
                  state_d      = IDLE;
               end
            end
         end

         DGNT: begin
            if (!(bus.dREN || bus.dWEN)) begin
               state_d = IDLE;
            end else begin
               bus.ramREN   = bus.dREN;
               bus.ramWEN   = bus.dWEN;
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               if (bus.ramstate == ACCESS) begin
                  bus.dwait = 1'b0;
                  if (bus.dREN) begin
                     bus.dload = bus.ramload;
                  end
                  // Only a data win over a waiting icache counts as starvation.
                  if (bus.iREN && (starve_cnt_q < LIMIT)) begin
                     starve_cnt_d = starve_cnt_q + 1'b1;
                  end
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign dbg_state_o      = state_q;
   assign dbg_starve_cnt_o = starve_cnt_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (STARVE_LIMIT=2): directed scenarios
// followed by randomized cache/RAM traffic, all checked every cycle against
// a transaction-level owner/streak model.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int LIM = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arb_state_t  dbg_state;
   logic [2:0]  dbg_cnt;

   mem_arbiter_if bus();

   mem_arbiter #(
      .STARVE_LIMIT (LIM),
      .CNT_W        (3)
   ) dut (
      .CLK              (clk),
      .RST              (rst),
      .bus              (bus),
      .dbg_state_o      (dbg_state),
      .dbg_starve_cnt_o (dbg_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];   // expected iload words of predicted fetch completions

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: 0 = nobody, 1 = icache holds the RAM, 2 = dcache holds the RAM.
   // streak: data wins over a waiting icache since its last fetch.
   int   owner  = 0;
   int   streak = 0;
   logic last_i_done, last_d_done;
   logic s_iwait, s_dwait, s_ramREN, s_ramWEN;
   logic [31:0] s_ramaddr, s_ramstore, s_iload, s_dload;

   // Called at posedge+1 with inputs already driven; checks at the negedge,
   // advances the model, and returns at the next posedge+1.
   task automatic step();
      logic e_ren, e_wen, e_iw, e_dw, want_d;
      logic [31:0] e_addr, e_store, e_il, e_dl;
      @(negedge clk);
      e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
      e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
      last_i_done = 0; last_d_done = 0;
      want_d = bus.dREN || bus.dWEN;

      if (owner == 1 && bus.iREN) begin
         e_ren  = 1;
         e_addr = bus.iaddr;
         if (bus.ramstate == ACCESS) begin
            last_i_done = 1;
            e_iw = 0;
            e_il = bus.ramload;
            exp_q.push_back(bus.ramload);
         end
      end else if (owner == 2 && want_d) begin
         e_ren   = bus.dREN;
         e_wen   = bus.dWEN;
         e_addr  = bus.daddr;
         e_store = bus.dstore;
         if (bus.ramstate == ACCESS) begin
            last_d_done = 1;
            e_dw = 0;
            e_dl = bus.dREN ? bus.ramload : 32'h0;
         end
      end

      check("iwait",    bus.iwait,    e_iw);
      check("dwait",    bus.dwait,    e_dw);
      check("ramREN",   bus.ramREN,   e_ren);
      check("ramWEN",   bus.ramWEN,   e_wen);
      check("ramaddr",  bus.ramaddr,  e_addr);
      check("ramstore", bus.ramstore, e_store);
      check("iload",    bus.iload,    e_il);
      check("dload",    bus.dload,    e_dl);
      check("starve",   dbg_cnt,      streak);
      check("bothlow",  (!bus.iwait && !bus.dwait), 0);
      if (!bus.iwait) begin
         if (exp_q.size() == 0) check("iq_empty", 1, 0);
         else                   check("iq_data", bus.iload, exp_q.pop_front());
      end

      s_iwait = bus.iwait;   s_dwait = bus.dwait;
      s_ramREN = bus.ramREN; s_ramWEN = bus.ramWEN;
      s_ramaddr = bus.ramaddr; s_ramstore = bus.ramstore;
      s_iload = bus.iload;   s_dload = bus.dload;

      if (rst) begin
         owner = 0; streak = 0;
      end else if (owner == 0) begin
         if (want_d && !(bus.iREN && streak >= LIM)) owner = 2;
         else if (bus.iREN)                          owner = 1;
      end else if (owner == 1) begin
         if (last_i_done) streak = 0;
         if (last_i_done || !bus.iREN) owner = 0;
      end else begin
         if (last_d_done && bus.iREN && streak < LIM) streak++;
         if (last_d_done || !want_d) owner = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int dn;
      int pulses;
      logic i_act, d_act;
      int r;

      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_iwait",  bus.iwait,   1);
      check("rst_dwait",  bus.dwait,   1);
      check("rst_ramREN", bus.ramREN,  0);
      check("rst_ramWEN", bus.ramWEN,  0);
      check("rst_addr",   bus.ramaddr, 0);
      check("rst_store",  bus.ramstore,0);
      check("rst_state",  dbg_state,   IDLE);
      check("rst_cnt",    dbg_cnt,     0);
      @(posedge clk); #1;
      rst = 0;

      // 1: lone fetch, two BUSY cycles then ACCESS
      bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
      step();
      step(); check("t1_addr", s_ramaddr, 32'h40); check("t1_ren", s_ramREN, 1);
      step(); check("t1_wait", s_iwait, 1);
      bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
      step(); check("t1_done", s_iwait, 0); check("t1_iload", s_iload, 32'hDEADBEEF);
      bus.iREN = 0;
      step();

      // 2: tie, data first, one bubble, then fetch
      bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h80;
      bus.ramload = 32'h0BADF00D;
      step();
      step(); check("t2_daddr", s_ramaddr, 32'h80); check("t2_dwait", s_dwait, 0);
      bus.dREN = 0;
      step(); check("t2_bubble", s_ramREN, 0);
      step(); check("t2_iaddr", s_ramaddr, 32'h44); check("t2_iwait", s_iwait, 0);
      bus.iREN = 0;
      step();

      // 3: starvation, back-to-back data with a waiting fetch
      bus.iREN = 1; bus.iaddr = 32'h50; bus.dREN = 1; bus.daddr = 32'h90;
      dn = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         dn += int'(last_d_done);
      end
      check("t3_dcount", dn, 2);
      step(); check("t3_igrant", s_iwait, 0); check("t3_iaddr", s_ramaddr, 32'h50);
      check("t3_cntclr", dbg_cnt, 0);
      bus.iREN = 0; bus.dREN = 0;
      step();

      // 4: write, one BUSY cycle
      bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; bus.ramstate = BUSY;
      step();
      step(); check("t4_wen", s_ramWEN, 1); check("t4_ren", s_ramREN, 0);
      check("t4_store", s_ramstore, 32'h12345678);
      bus.ramstate = ACCESS;
      step(); check("t4_dwait", s_dwait, 0); check("t4_dload", s_dload, 0);
      bus.dWEN = 0;
      step();

      // 5: ERROR never completes; dropping the request aborts silently
      bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = ERROR;
      step();
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         pulses += int'(!s_dwait);
         check("t5_hold", s_ramREN, 1);
      end
      check("t5_nopulse", pulses, 0);
      bus.dREN = 0;
      step(); check("t5_drop", s_ramREN, 0); check("t5_dwait", s_dwait, 1);
      check("t5_idle", dbg_state, IDLE);

      // 6: reset in the middle of a fetch grant
      bus.iREN = 1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
      step();
      step();
      rst = 1;
      step(); check("t6_held", s_ramREN, 1);
      rst = 0;
      step(); check("t6_ren", s_ramREN, 0); check("t6_iwait", s_iwait, 1);
      check("t6_cnt", dbg_cnt, 0);
      bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0006;
      step(); check("t6_regrant", s_iwait, 0); check("t6_iload", s_iload, 32'hCAFE0006);
      bus.iREN = 0;
      step();

      // random traffic
      i_act = 0; d_act = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!i_act && $urandom_range(0, 3) == 0) begin
            bus.iREN = 1; bus.iaddr = $urandom; i_act = 1;
         end else if (i_act && $urandom_range(0, 59) == 0) begin
            bus.iREN = 0; i_act = 0;
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) begin bus.dREN = 1; bus.dWEN = 0; end
            else                           begin bus.dREN = 0; bus.dWEN = 1; end
            bus.daddr = $urandom; bus.dstore = $urandom; d_act = 1;
         end else if (d_act && $urandom_range(0, 49) == 0) begin
            bus.dREN = 0; bus.dWEN = 0; d_act = 0;
         end
         r = $urandom_range(0, 9);
         if      (r < 4) bus.ramstate = ACCESS;
         else if (r < 6) bus.ramstate = BUSY;
         else if (r < 8) bus.ramstate = FREE;
         else            bus.ramstate = ERROR;
         bus.ramload = $urandom;
         rst = ($urandom_range(0, 199) == 0);
         step();
         if (last_i_done) begin
            if ($urandom_range(0, 1) == 0) begin bus.iREN = 0; i_act = 0; end
            else bus.iaddr = $urandom;
         end
         if (last_d_done) begin
            if ($urandom_range(0, 1) == 0) begin
               bus.dREN = 0; bus.dWEN = 0; d_act = 0;
            end else begin
               bus.daddr = $urandom; bus.dstore = $urandom;
            end
         end
      end
      rst = 0;
      check("q_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
